// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: queues host I2C commands, issues them one at a time to a single-transfer
// I2C master and returns one response per command, in order. Define I2C_SEQ_TIMEOUT_EN for the transfer timeout/abort.
module i2c_cmd_seq #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic       cmd_speed,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       m_start,
    output logic       m_abort,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic       m_speed,
    output logic [7:0] m_wdata,
    input  logic       m_ready,
    input  logic [7:0] m_rdata,
    input  logic       m_nack
);
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CMD_W = 17;
    localparam int unsigned RSP_W = 9;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("i2c_cmd_seq: FIFO_DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, PUSH_RSP} state_t;
    state_t state;

    logic [CMD_W-1:0] cmd_mem [FIFO_DEPTH];
    logic [PW-1:0]    cmd_wr_ptr, cmd_rd_ptr;
    logic [CW-1:0]    cmd_count;
    logic [RSP_W-1:0] rsp_mem [FIFO_DEPTH];
    logic [PW-1:0]    rsp_wr_ptr, rsp_rd_ptr;
    logic [CW-1:0]    rsp_count;
    logic [RSP_W-1:0] rsp_head, rsp_wdata;
    logic             cmd_push, cmd_pop, rsp_push, rsp_pop, rsp_full;
    logic [7:0]       hold_data, done_data;
    logic             hold_err;

    // Handshake/status decode, all from registered occupancy
    assign cmd_ready = (cmd_count != CW'(FIFO_DEPTH));
    assign rsp_valid = (rsp_count != '0);
    assign rsp_full  = (rsp_count == CW'(FIFO_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_pop   = (state == IDLE) && (cmd_count != '0) && m_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem[rsp_rd_ptr];
    assign rsp_data  = rsp_valid ? rsp_head[8:1] : 8'h00;
    assign rsp_err   = rsp_valid && rsp_head[0];
    assign done_data = m_rw ? m_rdata : 8'h00;

    // Completion is written straight into the response FIFO when it has room; PUSH_RSP parks otherwise
    assign rsp_push  = !rsp_full && (((state == WAIT_DONE) && m_ready) || (state == PUSH_RSP));
    assign rsp_wdata = (state == PUSH_RSP) ? {hold_data, hold_err} : {done_data, m_nack};

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_addr, cmd_rw, cmd_speed, cmd_wdata};
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_wdata;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PW'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + CW'(1);
                2'b01:   cmd_count <= cmd_count - CW'(1);
                default: cmd_count <= cmd_count;
            endcase
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + CW'(1);
                2'b01:   rsp_count <= rsp_count - CW'(1);
                default: rsp_count <= rsp_count;
            endcase
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_count;
    logic          tmo_hit;
    assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE))
                     && (tmo_count == TW'(TIMEOUT_CYCLES - 1));
`else
    assign m_abort = 1'b0;
`endif

    // Transfer sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_speed   <= 1'b0;
            m_wdata   <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            m_abort   <= 1'b0;
            tmo_count <= '0;
`endif
        end else begin
            m_start <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            m_abort <= 1'b0;
            if ((state == WAIT_BUSY) || (state == WAIT_DONE)) tmo_count <= tmo_count + TW'(1);
`endif
            case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        {m_addr, m_rw, m_speed, m_wdata} <= cmd_mem[cmd_rd_ptr];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start <= 1'b1;
                    state   <= WAIT_BUSY;
`ifdef I2C_SEQ_TIMEOUT_EN
                    tmo_count <= '0;
`endif
                end
                WAIT_BUSY: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    if (tmo_hit) begin
                        m_abort   <= 1'b1;
                        hold_data <= 8'h00;
                        hold_err  <= 1'b1;
                        state     <= PUSH_RSP;
                    end else
`endif
                    if (!m_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (m_ready) begin
                        hold_data <= done_data;
                        hold_err  <= m_nack;
                        state     <= rsp_full ? PUSH_RSP : IDLE;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        m_abort   <= 1'b1;
                        hold_data <= 8'h00;
                        hold_err  <= 1'b1;
                        state     <= PUSH_RSP;
                    end
`endif
                end
                PUSH_RSP: begin
                    if (!rsp_full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq: table of commands with hand-computed responses, a
// behavioural I2C master, and hand sequences for backpressure, timeout and mid-transfer reset.
module tb_i2c_cmd_seq;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int NV = 15;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int W0_BUSY = 10;
`else
    localparam int W0_BUSY = 20;
`endif

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_rw, cmd_speed;
    logic [6:0] cmd_addr, m_addr;
    logic [7:0] cmd_wdata, rsp_data, m_wdata, m_rdata;
    logic       rsp_valid, rsp_ready, rsp_err, m_start, m_abort, m_rw, m_speed, m_ready, m_nack;

    i2c_cmd_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
        .cmd_speed(cmd_speed), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw), .m_speed(m_speed),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_nack(m_nack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic       speed;
        logic [7:0] wdata;
        int         busy;
        logic [7:0] rdata;
        logic       nack;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vec [NV];
    int   checks = 0, failures = 0;
    int   cyc = 0, n_starts = 0, start_cyc = 0, rise_cyc = 0, stab_err = 0, abort_cnt = 0;
    bit   model_hang = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (m_abort) abort_cnt <= abort_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_addr  = v.addr;
        cmd_rw    = v.rw;
        cmd_speed = v.speed;
        cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_rsp(input string name);
        for (int g = 0; g < 300 && !rsp_valid; g++) tick();
        check({name, "_rsp_arrives"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_m_start"},   32'(m_start),   32'd0);
        check({tag, "_m_abort"},   32'(m_abort),   32'd0);
        check({tag, "_m_hold"},    32'({m_addr, m_rw, m_speed, m_wdata}), 32'd0);
    endtask

    // Behavioural master: busy for vec[n].busy cycles after each start, then returns rdata/nack
    initial begin
        vec_t cur;
        m_ready = 1'b1;
        m_rdata = 8'h00;
        m_nack  = 1'b0;
        forever begin
            tick();
            if (m_start) begin
                start_cyc = cyc;
                cur = '{addr: 7'h0, rw: 1'b0, speed: 1'b0, wdata: 8'h0, busy: 1,
                        rdata: 8'h0, nack: 1'b0, exp_data: 8'h0, exp_err: 1'b0};
                if (n_starts < NV) begin
                    cur = vec[n_starts];
                    check($sformatf("m_addr_%0d", n_starts), 32'(m_addr), 32'(cur.addr));
                    check($sformatf("m_rw_%0d", n_starts), 32'(m_rw), 32'(cur.rw));
                    check($sformatf("m_speed_%0d", n_starts), 32'(m_speed), 32'(cur.speed));
                    check($sformatf("m_wdata_%0d", n_starts), 32'(m_wdata), 32'(cur.wdata));
                end
                n_starts++;
                m_ready = 1'b0;
                m_rdata = 8'h00;
                m_nack  = 1'b0;
                if (model_hang) begin
                    while (model_hang) tick();
                end else begin
                    for (int k = 0; k < cur.busy; k++) begin
                        tick();
                        if (m_start || m_addr != cur.addr || m_rw != cur.rw || m_wdata != cur.wdata)
                            stab_err++;
                    end
                    m_rdata = cur.rdata;
                    m_nack  = cur.nack;
                end
                m_ready  = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    initial begin
        int sb, abort_c, g;
        bit saw_full;
        // addr rw speed wdata busy rdata nack -> exp_data exp_err
        vec[0]  = '{7'h48, 1'b0, 1'b0, 8'hA5, W0_BUSY, 8'h77, 1'b0, 8'h00, 1'b0};
        vec[1]  = '{7'h50, 1'b1, 1'b1, 8'h00, 3, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vec[2]  = '{7'h21, 1'b1, 1'b0, 8'h00, 2, 8'h5A, 1'b1, 8'h5A, 1'b1};
        vec[3]  = '{7'h7F, 1'b0, 1'b1, 8'hFF, 1, 8'h11, 1'b1, 8'h00, 1'b1};
        vec[4]  = '{7'h00, 1'b1, 1'b0, 8'h00, 1, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vec[5]  = '{7'h33, 1'b0, 1'b0, 8'h0C, 5, 8'h00, 1'b0, 8'h00, 1'b0};
        vec[6]  = '{7'h10, 1'b1, 1'b0, 8'h00, 2, 8'h81, 1'b0, 8'h81, 1'b0};
        vec[7]  = '{7'h11, 1'b0, 1'b1, 8'h02, 2, 8'h82, 1'b0, 8'h00, 1'b0};
        vec[8]  = '{7'h12, 1'b1, 1'b0, 8'h00, 2, 8'h83, 1'b1, 8'h83, 1'b1};
        vec[9]  = '{7'h13, 1'b1, 1'b1, 8'h00, 2, 8'h84, 1'b0, 8'h84, 1'b0};
        vec[10] = '{7'h14, 1'b0, 1'b0, 8'h05, 2, 8'h85, 1'b1, 8'h00, 1'b1};
        vec[11] = '{7'h15, 1'b1, 1'b0, 8'h00, 2, 8'h86, 1'b0, 8'h86, 1'b0};
        vec[12] = '{7'h16, 1'b1, 1'b1, 8'h00, 2, 8'h87, 1'b0, 8'h87, 1'b0};
        vec[13] = '{7'h17, 1'b0, 1'b0, 8'h08, 2, 8'h88, 1'b0, 8'h00, 1'b0};
        vec[14] = '{7'h18, 1'b1, 1'b0, 8'h00, 2, 8'h89, 1'b0, 8'h89, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_speed = 1'b0;
        cmd_wdata = '0; rsp_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // One command at a time through the table
        for (int i = 0; i < 6; i++) begin
            int push_c;
            sb = n_starts;
            check($sformatf("cmd_ready_idle_%0d", i), 32'(cmd_ready), 32'd1);
            drive_cmd(vec[i]);
            tick();
            push_c = cyc;
            cmd_valid = 1'b0;
            wait_rsp($sformatf("v%0d", i));
            check($sformatf("start_latency_%0d", i), 32'(start_cyc - push_c), 32'd2);
            check($sformatf("rsp_latency_%0d", i), 32'(cyc - rise_cyc), 32'd1);
            check($sformatf("rsp_data_%0d", i), 32'(rsp_data), 32'(vec[i].exp_data));
            check($sformatf("rsp_err_%0d", i), 32'(rsp_err), 32'(vec[i].exp_err));
            check($sformatf("one_start_%0d", i), 32'(n_starts - sb), 32'd1);
            pop_rsp();
            check($sformatf("rsp_popped_%0d", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: 9 commands with responses held off
        saw_full = 1'b0;
        for (int i = 6; i < 15; i++) begin
            g = 0;
            while (!cmd_ready && g < 500) begin
                saw_full = 1'b1;
                tick();
                g++;
            end
            drive_cmd(vec[i]);
            tick();
            cmd_valid = 1'b0;
        end
        repeat (80) tick();
        check("bp_saw_cmd_full", 32'(saw_full), 32'd1);
        check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check("bp_starts_stalled", 32'(n_starts), 32'd11);
        check("bp_hold_addr", 32'(m_addr), 32'(vec[10].addr));
        for (int k = 0; k < 9; k++) begin
            wait_rsp($sformatf("bp%0d", k));
            check($sformatf("bp_data_%0d", k), 32'(rsp_data), 32'(vec[6 + k].exp_data));
            check($sformatf("bp_err_%0d", k), 32'(rsp_err), 32'(vec[6 + k].exp_err));
            pop_rsp();
        end
        check("bp_drained", 32'(rsp_valid), 32'd0);
        check("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("bp_all_started", 32'(n_starts), 32'd15);
        check("hold_stable", 32'(stab_err), 32'd0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Master never comes back: expect abort TMO cycles after start and an error response
        sb = n_starts;
        model_hang = 1'b1;
        drive_cmd(vec[1]);
        tick();
        cmd_valid = 1'b0;
        for (g = 0; g < 50 && n_starts == sb; g++) tick();
        check("tmo_started", 32'(n_starts - sb), 32'd1);
        for (g = 0; g < 100 && !m_abort; g++) tick();
        abort_c = cyc;
        check("tmo_abort_seen", 32'(m_abort), 32'd1);
        check("tmo_abort_delay", 32'(abort_c - start_cyc), 32'(TMO));
        tick();
        check("tmo_abort_pulse", 32'(m_abort), 32'd0);
        wait_rsp("tmo");
        check("tmo_rsp_data", 32'(rsp_data), 32'd0);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        pop_rsp();
        model_hang = 1'b0;
        repeat (10) tick();
        check("tmo_late_ready_ignored", 32'(rsp_valid), 32'd0);
`endif

        // Reset while the master is busy: no response, no abort, outputs back to reset values
        sb = n_starts;
        model_hang = 1'b1;
        drive_cmd(vec[2]);
        tick();
        cmd_valid = 1'b0;
        for (g = 0; g < 50 && n_starts == sb; g++) tick();
        check("rst_mid_started", 32'(n_starts - sb), 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        model_hang = 1'b0;
        repeat (20) tick();
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_no_reissue", 32'(n_starts - sb), 32'd1);
`ifdef I2C_SEQ_TIMEOUT_EN
        check("abort_count", 32'(abort_cnt), 32'd1);
`else
        check("abort_count", 32'(abort_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
